bram_fifo_ctrl: RTL and testbench

//   Controller that drives the write and read ports of the team's simple dual-port BRAM
//   (Wr_En/W_Addr/Wr_Data, Rd_En/R_Addr/Rd_Data).
//   It presents that BRAM as a synchronous FIFO with push/pop handshakes, occupancy count and flags.
//   It is the client/master side of the BRAM interface and sits between a producer stream and a consumer stream.
//   The attached BRAM returns Rd_Data exactly one i_Clk after Rd_En is sampled high.

---
 rtl/bram_fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - synchronous FIFO controller driving a simple dual-port BRAM
// Pointers, occupancy and flags are held here; the BRAM stores the data with 1-cycle read latency.
module bram_fifo_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Wr_DV,
    input  logic [WIDTH-1:0]      i_Wr_Data,
    input  logic                  i_Rd_En,
    output logic                  o_Rd_DV,
    output logic [WIDTH-1:0]      o_Rd_Data,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic                  o_AF,
    output logic                  o_AE,
    output logic [DEPTH_BITS:0]   o_Count,
    output logic                  o_Overflow,
    output logic                  o_Underflow,
    output logic                  o_Bram_Wr_En,
    output logic [DEPTH_BITS-1:0] o_Bram_W_Addr,
    output logic [WIDTH-1:0]      o_Bram_Wr_Data,
    output logic                  o_Bram_Rd_En,
    output logic [DEPTH_BITS-1:0] o_Bram_R_Addr,
    input  logic [WIDTH-1:0]      i_Bram_Rd_Data
);

    localparam logic [DEPTH_BITS:0] CNT_MAX = (DEPTH_BITS+1)'(1 << DEPTH_BITS);
    localparam logic [DEPTH_BITS:0] CNT_AF  = (DEPTH_BITS+1)'(AF_LEVEL);
    localparam logic [DEPTH_BITS:0] CNT_AE  = (DEPTH_BITS+1)'(AE_LEVEL);

    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  rd_dv_q, rd_dv_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic push_ok;
    logic pop_ok;

    // Full rejects pushes and empty rejects pops regardless of the opposite side,
    // so the BRAM never sees a same-address read and write on one edge.
    always_comb begin
        push_ok  = i_Wr_DV & ~full_q;
        pop_ok   = i_Rd_En & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_MAX);
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_AF);
        ae_d    = (count_d <= CNT_AE);
        rd_dv_d = pop_ok;
        ovf_d   = ovf_q | (i_Wr_DV & full_q);
        udf_d   = udf_q | (i_Rd_En & empty_q);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            rd_dv_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            rd_dv_q  <= rd_dv_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Enables are gated by reset so the BRAM is untouched while reset is held.
    assign o_Bram_Wr_En   = push_ok & i_Rst_L;
    assign o_Bram_Rd_En   = pop_ok & i_Rst_L;
    assign o_Bram_W_Addr  = wr_ptr_q;
    assign o_Bram_R_Addr  = rd_ptr_q;
    assign o_Bram_Wr_Data = i_Wr_Data;

    assign o_Rd_DV     = rd_dv_q;
    assign o_Rd_Data   = i_Bram_Rd_Data;
    assign o_Full      = full_q;
    assign o_Empty     = empty_q;
    assign o_AF        = af_q;
    assign o_AE        = ae_q;
    assign o_Count     = count_q;
    assign o_Overflow  = ovf_q;
    assign o_Underflow = udf_q;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb/tb_bram_fifo_ctrl.sv - directed bench for bram_fifo_ctrl with a BRAM model and data scoreboard
module tb_bram_fifo_ctrl;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L;
    logic       i_Wr_DV;
    logic [7:0] i_Wr_Data;
    logic       i_Rd_En;
    logic       o_Rd_DV;
    logic [7:0] o_Rd_Data;
    logic       o_Full, o_Empty, o_AF, o_AE;
    logic [4:0] o_Count;
    logic       o_Overflow, o_Underflow;
    logic       o_Bram_Wr_En, o_Bram_Rd_En;
    logic [3:0] o_Bram_W_Addr, o_Bram_R_Addr;
    logic [7:0] o_Bram_Wr_Data;
    logic [7:0] bram_rd;

    always #5 i_Clk = ~i_Clk;

    bram_fifo_ctrl dut (
        .i_Clk          (i_Clk),
        .i_Rst_L        (i_Rst_L),
        .i_Wr_DV        (i_Wr_DV),
        .i_Wr_Data      (i_Wr_Data),
        .i_Rd_En        (i_Rd_En),
        .o_Rd_DV        (o_Rd_DV),
        .o_Rd_Data      (o_Rd_Data),
        .o_Full         (o_Full),
        .o_Empty        (o_Empty),
        .o_AF           (o_AF),
        .o_AE           (o_AE),
        .o_Count        (o_Count),
        .o_Overflow     (o_Overflow),
        .o_Underflow    (o_Underflow),
        .o_Bram_Wr_En   (o_Bram_Wr_En),
        .o_Bram_W_Addr  (o_Bram_W_Addr),
        .o_Bram_Wr_Data (o_Bram_Wr_Data),
        .o_Bram_Rd_En   (o_Bram_Rd_En),
        .o_Bram_R_Addr  (o_Bram_R_Addr),
        .i_Bram_Rd_Data (bram_rd)
    );

    logic [7:0] mem [16];
    always @(posedge i_Clk) begin
        if (o_Bram_Wr_En) mem[o_Bram_W_Addr] <= o_Bram_Wr_Data;
        if (o_Bram_Rd_En) bram_rd <= mem[o_Bram_R_Addr];
    end

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb [$];
    int         m_count;
    logic [3:0] m_wp, m_rp;
    logic       m_ovf, m_udf, m_dv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_wp    = '0;
        m_rp    = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_dv    = 1'b0;
        sb.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "/count"}, 32'(o_Count), 32'(m_count));
        chk({tag, "/empty"}, 32'(o_Empty), 32'(m_count == 0));
        chk({tag, "/full"},  32'(o_Full),  32'(m_count == 16));
        chk({tag, "/af"},    32'(o_AF),    32'(m_count >= 12));
        chk({tag, "/ae"},    32'(o_AE),    32'(m_count <= 4));
        chk({tag, "/ovf"},   32'(o_Overflow),  32'(m_ovf));
        chk({tag, "/udf"},   32'(o_Underflow), 32'(m_udf));
        chk({tag, "/rd_dv"}, 32'(o_Rd_DV), 32'(m_dv));
        if (m_dv) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL %s/sb_empty: observed read data %0h required none", tag, o_Rd_Data);
            end else begin
                chk({tag, "/rd_data"}, 32'(o_Rd_Data), 32'(sb.pop_front()));
            end
        end
    endtask

    // One clock: check combinational BRAM drive before the edge, registered state after it.
    task automatic cycle(input string tag, input logic wr, input logic [7:0] d, input logic rd);
        bit ep, eq;
        i_Wr_DV   = wr;
        i_Wr_Data = d;
        i_Rd_En   = rd;
        #1;
        ep = wr && (m_count != 16);
        eq = rd && (m_count != 0);
        chk({tag, "/bram_wr_en"}, 32'(o_Bram_Wr_En), 32'(ep));
        chk({tag, "/bram_rd_en"}, 32'(o_Bram_Rd_En), 32'(eq));
        if (ep) begin
            chk({tag, "/w_addr"},  32'(o_Bram_W_Addr),  32'(m_wp));
            chk({tag, "/wr_data"}, 32'(o_Bram_Wr_Data), 32'(d));
        end
        if (eq) chk({tag, "/r_addr"}, 32'(o_Bram_R_Addr), 32'(m_rp));
        @(posedge i_Clk);
        #1;
        if (wr && !ep) m_ovf = 1'b1;
        if (rd && !eq) m_udf = 1'b1;
        if (ep) begin
            sb.push_back(d);
            m_wp = m_wp + 4'd1;
        end
        if (eq) m_rp = m_rp + 4'd1;
        m_count = m_count + int'(ep) - int'(eq);
        m_dv    = eq;
        i_Wr_DV = 1'b0;
        i_Rd_En = 1'b0;
        check_state(tag);
    endtask

    // Reset is asserted with both requests high to prove the enables are forced low.
    task automatic do_reset(input string tag);
        i_Wr_DV = 1'b1;
        i_Rd_En = 1'b1;
        i_Rst_L = 1'b0;
        #1;
        chk({tag, "/rst_empty"},  32'(o_Empty),      32'd1);
        chk({tag, "/rst_count"},  32'(o_Count),      32'd0);
        chk({tag, "/rst_rd_dv"},  32'(o_Rd_DV),      32'd0);
        chk({tag, "/rst_wr_en"},  32'(o_Bram_Wr_En), 32'd0);
        chk({tag, "/rst_rd_en"},  32'(o_Bram_Rd_En), 32'd0);
        chk({tag, "/rst_full"},   32'(o_Full),       32'd0);
        chk({tag, "/rst_ovf"},    32'(o_Overflow),   32'd0);
        chk({tag, "/rst_udf"},    32'(o_Underflow),  32'd0);
        model_reset();
        @(posedge i_Clk);
        @(posedge i_Clk);
        #1;
        i_Wr_DV = 1'b0;
        i_Rd_En = 1'b0;
        i_Rst_L = 1'b1;
        check_state({tag, "/post_rst"});
    endtask

    initial begin
        i_Rst_L   = 1'b1;
        i_Wr_DV   = 1'b0;
        i_Rd_En   = 1'b0;
        i_Wr_Data = 8'h00;
        model_reset();
        #2;
        do_reset("init");

        cycle("pop_empty", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cycle("udf_sticky", 1'b0, 8'h00, 1'b0);

        do_reset("clr_udf");
        cycle("push_a5", 1'b1, 8'hA5, 1'b0);
        cycle("pop_a5",  1'b0, 8'h00, 1'b1);
        cycle("rd_a5",   1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0);
        cycle("push17", 1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < 16; i++) cycle("drain", 1'b0, 8'h00, 1'b1);
        cycle("drain_tail", 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 5; i++) cycle("wrap_pre", 1'b1, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 40; i++) cycle("wrap", 1'b1, 8'(8'h40 + i), 1'b1);
        for (int i = 0; i < 6; i++) cycle("wrap_drain", 1'b0, 8'h00, 1'b1);

        do_reset("pre_full");
        for (int i = 0; i < 16; i++) cycle("fill2", 1'b1, 8'(8'hC0 + i), 1'b0);
        cycle("full_pp", 1'b1, 8'h77, 1'b1);
        chk("full_pp/count15", 32'(o_Count), 32'd15);
        for (int i = 0; i < 15; i++) cycle("drain2", 1'b0, 8'h00, 1'b1);
        cycle("empty_pp", 1'b1, 8'h3C, 1'b1);
        chk("empty_pp/count1", 32'(o_Count), 32'd1);
        cycle("empty_pp_pop", 1'b0, 8'h00, 1'b1);
        cycle("empty_pp_rd",  1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 4; i++) cycle("mid", 1'b1, 8'(8'h10 + i), 1'b0);
        cycle("mid_pop", 1'b0, 8'h00, 1'b1);
        do_reset("mid_rst");
        cycle("after_rst_push", 1'b1, 8'h5A, 1'b0);
        cycle("after_rst_pop",  1'b0, 8'h00, 1'b1);
        cycle("after_rst_rd",   1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
